combined_window_integrator: RTL and testbench
=============================================

Name: combined_window_integrator

Overview:
- Downstream consumer of the factor-4 pulse combiner's 16-bit signed output stream.
- On each trigger, waits a programmable delay, then integrates a programmable window of combined samples.
- Also tracks the window peak and its sample index.
- Presents one result set per trigger with a single-cycle valid strobe, for readout by the monitor/feedback logic.

Parameters:
- DATA_W, 16, width of signed input sample (combiner output width).
- CNT_W, 10, width of gate delay/length counters; max window 2^CNT_W-1 samples.
- SUM_W, DATA_W+CNT_W (26), width of signed accumulator; sized so no overflow is possible.

Ports:
- clk  in  1  system clock (357 MHz sample clock)
- rst  in  1  synchronous, active-high reset
- trig  in  1  single-cycle trigger; marks window reference
- din  in  DATA_W  signed combined sample, one per clk
- gate_start  in  CNT_W  delay from trigger to first integrated sample
- gate_len  in  CNT_W  number of samples integrated
- sum  out  SUM_W  signed window sum
- peak  out  DATA_W  signed maximum sample in window
- peak_idx  out  CNT_W  offset of peak within window (0 = first sample)
- res_valid  out  1  one-cycle strobe; sum/peak/peak_idx valid
- busy  out  1  high in any state other than IDLE
- trig_missed  out  1  sticky; set by trig while busy, cleared by next accepted trig or rst

Behaviour:
- Reset: state IDLE; sum=0, peak=0, peak_idx=0, res_valid=0, busy=0, trig_missed=0; all counters and the accumulator are cleared.
- Reset mid-operation aborts the window; no res_valid is produced.
- gate_start/gate_len are latched on the accepted trig; later changes do not affect the window in progress.
- FSM states: IDLE, DELAY, ACCUM, DONE.
  - IDLE: on trig → DELAY if gate_start>0; else ACCUM if gate_len>0; else DONE. Accumulator cleared, peak reset to most-negative (-2^(DATA_W-1)), trig_missed cleared.
  - DELAY: counts gate_start cycles → ACCUM if gate_len>0, else DONE.
  - ACCUM: accumulates gate_len samples → DONE.
  - DONE: registers results, res_valid=1 for exactly one cycle → IDLE.
- Timing: trig sampled at edge k. The integrated samples are din at edges k+1+gate_start … k+gate_start+gate_len. res_valid is high in the cycle after edge k+gate_start+gate_len+1.
- Zero-length windows: gate_len=0 gives sum=0, peak=0, peak_idx=0, with res_valid 2 cycles after trig (gate_start=0).
- Arithmetic: din is sign-extended to SUM_W before addition; two's complement; no saturation needed.
- Peak: update only on strictly greater sample, so ties keep the earliest index.
- sum/peak/peak_idx hold their values until the next DONE.
- trig while busy (including DONE): ignored, trig_missed set; the window continues unaffected.
- trig in the same cycle as rst: rst wins.
- Back-to-back: a trig in the IDLE cycle immediately after DONE is accepted.

Optional Feature:
- Macro PEDESTAL_SUB_EN.
- Defined:
  - Adds input port pedestal (DATA_W, signed).
  - pedestal is latched at accepted trig.
  - Each integrated sample becomes din-pedestal, computed at DATA_W+1 bits.
  - SUM_W grows by 1.
  - peak compares the pedestal-subtracted value and peak widens to DATA_W+1.
- Undefined: no pedestal port; raw din is integrated. Widths are as in Parameters.

Decomposition:
- Shared package (combiner_pkg):
  - FSM state enumeration (IDLE/DELAY/ACCUM/DONE);
  - default DATA_W, CNT_W;
  - the SUM_W derivation function;
  - the most-negative-sample constant.
- One natural sub-module: window_peak_tracker. It takes sample, sample-enable, clear and index, and returns a running max and its index. It is reusable by other monitor stages.
- The FSM and accumulator stay in the top.

Test Plan:
- gate_start=3, gate_len=4, din ramp 0,1,2,… (din[n]=n) with trig at n=10 → sum=14+15+16+17=62, peak=17, peak_idx=3, res_valid at edge 18.
- gate_start=0, gate_len=1023, din constant -32768 → sum=-33,521,664, no overflow; peak=-32768, peak_idx=0 (tie rule).
- Second trig 5 cycles after the first (gate_len=20) → trig_missed=1, first result unchanged; the next accepted trig clears trig_missed.
- rst asserted mid-ACCUM → no res_valid; all outputs 0 next cycle; a following trig produces a correct fresh result.
- gate_start=2, gate_len=0 → res_valid 4 cycles after trig with sum=0, peak=0; then an immediate re-trig in IDLE is accepted.
- PEDESTAL_SUB_EN defined, pedestal=100, gate_len=4, din=100,150,50,100 → sum=0, peak=50, peak_idx=1.

Source files
------------

// File: rtl/combiner_pkg.sv
// Shared definitions for the combined-sample monitor stages: FSM states, default widths,
// accumulator sizing and the most-negative sample constant.
package combiner_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_CNT_W  = 10;

   typedef enum logic [1:0] {
      StIdle,
      StDelay,
      StAccum,
      StDone
   } state_t;

   localparam logic signed [DEF_DATA_W-1:0] MOST_NEG_SAMPLE = {1'b1, {(DEF_DATA_W-1){1'b0}}};

   // A window of at most 2^cnt_w-1 samples cannot overflow data_w+cnt_w bits.
   function automatic int sum_width(input int data_w, input int cnt_w);
      return data_w + cnt_w;
   endfunction

endpackage

// File: rtl/window_peak_tracker.sv
// Running signed maximum and the index at which it was first reached.
module window_peak_tracker #(
   parameter int W  = 16,
   parameter int IW = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                en,
   input  logic signed [W-1:0] sample,
   input  logic [IW-1:0]       idx,
   output logic signed [W-1:0] max_val,
   output logic [IW-1:0]       max_idx
);

   localparam logic signed [W-1:0] MinVal = {1'b1, {(W-1){1'b0}}};

   // Strictly-greater update keeps the earliest index on ties.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         max_val <= MinVal;
         max_idx <= '0;
      end else if (en && (sample > max_val)) begin
         max_val <= sample;
         max_idx <= idx;
      end
   end

endmodule

// File: rtl/combined_window_integrator.sv
// Triggered delayed-window integrator with peak tracking for the combiner output stream.
// Optional pedestal subtraction is enabled by defining PEDESTAL_SUB_EN.
module combined_window_integrator
   import combiner_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W,
`ifdef PEDESTAL_SUB_EN
   localparam int SAMP_W = DATA_W + 1,
`else
   localparam int SAMP_W = DATA_W,
`endif
   parameter int SUM_W  = sum_width(SAMP_W, CNT_W)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     trig,
   input  logic signed [DATA_W-1:0] din,
`ifdef PEDESTAL_SUB_EN
   input  logic signed [DATA_W-1:0] pedestal,
`endif
   input  logic [CNT_W-1:0]         gate_start,
   input  logic [CNT_W-1:0]         gate_len,
   output logic signed [SUM_W-1:0]  sum,
   output logic signed [SAMP_W-1:0] peak,
   output logic [CNT_W-1:0]         peak_idx,
   output logic                     res_valid,
   output logic                     busy,
   output logic                     trig_missed
);

   state_t                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CNT_W-1:0]          idx_q;
   logic [CNT_W-1:0]          gl_q;
   logic signed [SUM_W-1:0]   acc_q;
   logic signed [SAMP_W-1:0]  samp;
   logic signed [SAMP_W-1:0]  trk_max;
   logic [CNT_W-1:0]          trk_idx;
   logic                      accept;
   logic                      accum_en;

`ifdef PEDESTAL_SUB_EN
   logic signed [DATA_W-1:0] ped_q;
   assign samp = {din[DATA_W-1], din} - {ped_q[DATA_W-1], ped_q};
`else
   assign samp = din;
`endif

   assign accept   = (state_q == StIdle) && trig;
   assign accum_en = (state_q == StAccum);
   assign busy     = (state_q != StIdle);

   window_peak_tracker #(
      .W  (SAMP_W),
      .IW (CNT_W)
   ) u_peak (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept),
      .en      (accum_en),
      .sample  (samp),
      .idx     (idx_q),
      .max_val (trk_max),
      .max_idx (trk_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         gl_q        <= '0;
         acc_q       <= '0;
         sum         <= '0;
         peak        <= '0;
         peak_idx    <= '0;
         res_valid   <= 1'b0;
         trig_missed <= 1'b0;
`ifdef PEDESTAL_SUB_EN
         ped_q       <= '0;
`endif
      end else begin
         res_valid <= 1'b0;
         if (trig && (state_q != StIdle)) trig_missed <= 1'b1;
         case (state_q)
            StIdle: begin
               if (trig) begin
                  gl_q        <= gate_len;
                  acc_q       <= '0;
                  idx_q       <= '0;
                  trig_missed <= 1'b0;
`ifdef PEDESTAL_SUB_EN
                  ped_q       <= pedestal;
`endif
                  if (gate_start != '0) begin
                     state_q <= StDelay;
                     cnt_q   <= gate_start;
                  end else if (gate_len != '0) begin
                     state_q <= StAccum;
                     cnt_q   <= gate_len;
                  end else begin
                     state_q <= StDone;
                  end
               end
            end
            StDelay: begin
               if (cnt_q == CNT_W'(1)) begin
                  if (gl_q != '0) begin
                     state_q <= StAccum;
                     cnt_q   <= gl_q;
                  end else begin
                     state_q <= StDone;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StAccum: begin
               acc_q <= acc_q + {{(SUM_W-SAMP_W){samp[SAMP_W-1]}}, samp};
               idx_q <= idx_q + 1'b1;
               if (cnt_q == CNT_W'(1)) state_q <= StDone;
               else cnt_q <= cnt_q - 1'b1;
            end
            StDone: begin
               sum <= acc_q;
               // An empty window reports zero rather than the tracker's clear value.
               if (gl_q == '0) begin
                  peak     <= '0;
                  peak_idx <= '0;
               end else begin
                  peak     <= trk_max;
                  peak_idx <= trk_idx;
               end
               res_valid <= 1'b1;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_combined_window_integrator.sv
// Scoreboard bench: each window's expected result is modelled from the driven samples.
module tb_combined_window_integrator;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 10;
`ifdef PEDESTAL_SUB_EN
   localparam int SAMP_W = DATA_W + 1;
`else
   localparam int SAMP_W = DATA_W;
`endif
   localparam int SUM_W  = SAMP_W + CNT_W;
   localparam longint MinPeak = -(longint'(1) << (SAMP_W - 1));

   logic                     clk;
   logic                     rst;
   logic                     trig;
   logic signed [DATA_W-1:0] din;
   logic [CNT_W-1:0]         gate_start;
   logic [CNT_W-1:0]         gate_len;
   logic signed [SUM_W-1:0]  sum;
   logic signed [SAMP_W-1:0] peak;
   logic [CNT_W-1:0]         peak_idx;
   logic                     res_valid;
   logic                     busy;
   logic                     trig_missed;
`ifdef PEDESTAL_SUB_EN
   logic signed [DATA_W-1:0] pedestal;
`endif

   typedef struct {
      longint s;
      longint p;
      int     i;
   } exp_t;

   exp_t                     sb[$];
   logic signed [DATA_W-1:0] pat[0:1099];
   int                       n_run;
   int                       n_fail;

   combined_window_integrator dut (
      .clk         (clk),
      .rst         (rst),
      .trig        (trig),
      .din         (din),
`ifdef PEDESTAL_SUB_EN
      .pedestal    (pedestal),
`endif
      .gate_start  (gate_start),
      .gate_len    (gate_len),
      .sum         (sum),
      .peak        (peak),
      .peak_idx    (peak_idx),
      .res_valid   (res_valid),
      .busy        (busy),
      .trig_missed (trig_missed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic fill_random();
      for (int j = 0; j < 1100; j++) pat[j] = DATA_W'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         trig = 1'b0;
      end
   endtask

   // Drives one trigger at j=0 and returns at the negedge where res_valid is first seen,
   // so a following call is a back-to-back trigger.
   task automatic run_window(input int gs, input int gl, input int ped, input int missed_j);
      exp_t   e;
      exp_t   got;
      longint s;
      int     lat;
      e.s = 0;
      e.p = (gl == 0) ? 0 : MinPeak;
      e.i = 0;
      for (int n = 0; n < gl; n++) begin
`ifdef PEDESTAL_SUB_EN
         s = longint'(pat[gs + 1 + n]) - longint'(ped);
`else
         s = longint'(pat[gs + 1 + n]);
`endif
         e.s += s;
         if (s > e.p) begin
            e.p = s;
            e.i = n;
         end
      end
      sb.push_back(e);
      lat = -1;
      for (int j = 0; j <= gs + gl + 8; j++) begin
         @(negedge clk);
         if (j > 0) begin
            if (res_valid) begin
               lat = j;
               break;
            end
            if (j == 1) begin
               n_run++;
               if (busy !== 1'b1) begin
                  n_fail++;
                  $display("FAIL busy_after_trig got %b want 1", busy);
               end
               n_run++;
               if (trig_missed !== 1'b0) begin
                  n_fail++;
                  $display("FAIL missed_cleared got %b want 0", trig_missed);
               end
            end
            if (missed_j > 0 && j == missed_j + 1) begin
               n_run++;
               if (trig_missed !== 1'b1) begin
                  n_fail++;
                  $display("FAIL missed_set got %b want 1", trig_missed);
               end
            end
         end
         trig = (j == 0) || (missed_j > 0 && j == missed_j);
         din  = pat[j];
         if (j == 0) begin
            gate_start = CNT_W'(gs);
            gate_len   = CNT_W'(gl);
         end else begin
            gate_start = CNT_W'($urandom);
            gate_len   = CNT_W'($urandom);
         end
`ifdef PEDESTAL_SUB_EN
         pedestal = (j == 0) ? DATA_W'(ped) : DATA_W'($urandom);
`endif
      end
      n_run++;
      if (lat != gs + gl + 2) begin
         n_fail++;
         $display("FAIL latency gs=%0d gl=%0d got %0d want %0d", gs, gl, lat, gs + gl + 2);
      end
      got = sb.pop_front();
      n_run++;
      if (longint'(sum) !== got.s) begin
         n_fail++;
         $display("FAIL sum gs=%0d gl=%0d got %0d want %0d", gs, gl, sum, got.s);
      end
      n_run++;
      if (longint'(peak) !== got.p) begin
         n_fail++;
         $display("FAIL peak gs=%0d gl=%0d got %0d want %0d", gs, gl, peak, got.p);
      end
      n_run++;
      if (int'(peak_idx) !== got.i) begin
         n_fail++;
         $display("FAIL peak_idx gs=%0d gl=%0d got %0d want %0d", gs, gl, peak_idx, got.i);
      end
   endtask

   task automatic test_reset();
      // trig held alongside rst must be ignored
      rst = 1'b1;
      trig = 1'b1;
      repeat (3) @(negedge clk);
      n_run++;
      if (sum !== '0 || peak !== '0 || peak_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_results got %0d/%0d/%0d want 0/0/0", sum, peak, peak_idx);
      end
      n_run++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || trig_missed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags got %b%b%b want 000", res_valid, busy, trig_missed);
      end
      rst = 1'b0;
      trig = 1'b0;
      idle(2);
   endtask

   task automatic test_ramp();
      for (int j = 0; j < 1100; j++) pat[j] = DATA_W'(10 + j);
      run_window(3, 4, 0, 0);
      idle(3);
   endtask

   task automatic test_long_negative();
      for (int j = 0; j < 1100; j++) pat[j] = 16'sh8000;
      run_window(0, 1023, 0, 0);
      idle(3);
   endtask

   task automatic test_trig_missed();
      fill_random();
      run_window(0, 20, 0, 5);
      idle(3);
      n_run++;
      if (trig_missed !== 1'b1) begin
         n_fail++;
         $display("FAIL missed_sticky got %b want 1", trig_missed);
      end
      fill_random();
      run_window(1, 3, 0, 0);
      idle(3);
   endtask

   task automatic test_reset_mid();
      int seen;
      fill_random();
      for (int j = 0; j <= 5; j++) begin
         @(negedge clk);
         trig       = (j == 0) || (j == 5);
         rst        = (j == 5);
         din        = pat[j];
         gate_start = CNT_W'(1);
         gate_len   = CNT_W'(10);
      end
      @(negedge clk);
      rst  = 1'b0;
      trig = 1'b0;
      n_run++;
      if (sum !== '0 || peak !== '0 || peak_idx !== '0) begin
         n_fail++;
         $display("FAIL midrst_results got %0d/%0d/%0d want 0/0/0", sum, peak, peak_idx);
      end
      n_run++;
      if (busy !== 1'b0 || trig_missed !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_flags got %b%b want 00", busy, trig_missed);
      end
      seen = 0;
      for (int j = 0; j < 20; j++) begin
         if (res_valid) seen++;
         @(negedge clk);
      end
      n_run++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL midrst_no_valid got %0d strobes want 0", seen);
      end
      fill_random();
      run_window(1, 10, 0, 0);
      idle(3);
   endtask

   task automatic test_zero_len_back_to_back();
      fill_random();
      run_window(2, 0, 0, 0);
      run_window(0, 0, 0, 0);
      fill_random();
      run_window(0, 3, 0, 0);
      run_window(4, 2, 0, 0);
      idle(3);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         fill_random();
         run_window(int'($urandom_range(0, 6)), int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 400)), 0);
         idle(int'($urandom_range(0, 2)));
      end
      idle(3);
   endtask

`ifdef PEDESTAL_SUB_EN
   task automatic test_pedestal();
      fill_random();
      pat[1] = 16'sd100;
      pat[2] = 16'sd150;
      pat[3] = 16'sd50;
      pat[4] = 16'sd100;
      run_window(0, 4, 100, 0);
      idle(3);
   endtask
`endif

   initial begin
      n_run      = 0;
      n_fail     = 0;
      rst        = 1'b1;
      trig       = 1'b0;
      din        = '0;
      gate_start = '0;
      gate_len   = '0;
`ifdef PEDESTAL_SUB_EN
      pedestal   = '0;
`endif
      test_reset();
      test_ramp();
      test_long_negative();
      test_trig_missed();
      test_reset_mid();
      test_zero_len_back_to_back();
      test_random();
`ifdef PEDESTAL_SUB_EN
      test_pedestal();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
